// File: rtl/result_packer.sv
// result_packer
//   Write-back stage after the edge-detection accelerator. Packs four 8-bit
//   result pixels into one 32-bit word (first pixel in [7:0]) and writes the
//   words through a granted memory port starting at BASE_ADDR. One pack
//   register and one hold register absorb memory back-pressure. done marks a
//   fully written frame and is held until the next accepted start.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-low reset
//     start      one-cycle frame start pulse (honoured in IDLE and DONE)
//     pix_in     result pixel
//     pix_valid  pix_in valid this cycle
//     pix_ready  pixel accepted on this edge when pix_valid is also high
//     mem_en     write request (hold register valid)
//     mem_we     write enable, always equal to mem_en
//     mem_addr   word address, BASE_ADDR + write index
//     mem_di     write data
//     mem_grant  port granted; a write completes on mem_en && mem_grant
//     done       frame fully written
module result_packer #(
  parameter int WIDTH      = 352,
  parameter int HEIGHT     = 288,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = WIDTH * HEIGHT / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_di,
  input  logic                  mem_grant,
  output logic                  done
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int NWORD = NPIX / 4;
  localparam int PIX_W = $clog2(NPIX);

  localparam logic [PIX_W-1:0]      LAST_PIX  = PIX_W'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NWORD - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [2:0]            pack_cnt;
  logic [31:0]           pack_data;
  logic                  hold_valid;
  logic [31:0]           hold_data;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [PIX_W-1:0]      pix_cnt;

  logic        accept;
  logic        wr_done;
  logic        hold_free;
  logic        start_frame;
  logic        pack_to_hold;
  logic        byte_to_hold;
  logic [31:0] word_in;

  always_comb begin
    pix_ready    = (state == RUN) && (pack_cnt != 3'd4);
    accept       = pix_valid && pix_ready;
    wr_done      = hold_valid && mem_grant;
    // Hold can take a new word if it is empty or its write retires this edge.
    hold_free    = !hold_valid || mem_grant;
    start_frame  = start && ((state == IDLE) || (state == DONE));
    word_in      = {pix_in, pack_data[23:0]};
    pack_to_hold = (pack_cnt == 3'd4) && hold_free;
    byte_to_hold = accept && (pack_cnt == 3'd3) && hold_free;
    mem_en       = hold_valid;
    mem_we       = hold_valid;
    mem_di       = hold_data;
    mem_addr     = BASE + wr_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (accept && (pix_cnt == LAST_PIX)) state <= DRAIN;
        end
        DRAIN: begin
          if (wr_done && (wr_idx == LAST_WORD)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_cnt   <= '0;
      pack_data  <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      wr_idx     <= '0;
      pix_cnt    <= '0;
    end else if (start_frame) begin
      pack_cnt   <= '0;
      pack_data  <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      wr_idx     <= '0;
      pix_cnt    <= '0;
    end else begin
      if (accept) pix_cnt <= pix_cnt + 1'b1;
      if (wr_done) wr_idx <= wr_idx + 1'b1;

      // A retiring write and a new load on the same edge keep hold valid.
      if (pack_to_hold) begin
        hold_data  <= pack_data;
        hold_valid <= 1'b1;
      end else if (byte_to_hold) begin
        hold_data  <= word_in;
        hold_valid <= 1'b1;
      end else if (wr_done) begin
        hold_valid <= 1'b0;
      end

      // pack_cnt==4 blocks accept, so the two branches never overlap.
      if (pack_to_hold) begin
        pack_cnt <= '0;
      end else if (accept) begin
        if (pack_cnt == 3'd3) begin
          if (hold_free) begin
            pack_cnt <= '0;
          end else begin
            pack_cnt  <= 3'd4;
            pack_data <= word_in;
          end
        end else begin
          pack_data[{pack_cnt[1:0], 3'b000} +: 8] <= pix_in;
          pack_cnt <= pack_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer on a reduced 16x3 frame
// (48 pixels, 12 words, base address 12).
module tb_result_packer;

  localparam int W     = 16;
  localparam int H     = 3;
  localparam int AW    = 16;
  localparam int BASE  = W * H / 4;
  localparam int NPIX  = W * H;
  localparam int NWORD = NPIX / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_di;
  logic          mem_grant;
  logic          done;

  result_packer #(
    .WIDTH(W),
    .HEIGHT(H),
    .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pix_in(pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_di(mem_di),
    .mem_grant(mem_grant),
    .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  int pidx   = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int f, input int i);
    int t;
    t = i + f * 37;
    return t[7:0];
  endfunction

  function automatic logic [47:0] exp_word(input int f, input int w);
    return {16'(BASE + w), pv(f, 4*w+3), pv(f, 4*w+2), pv(f, 4*w+1), pv(f, 4*w)};
  endfunction

  // Inputs change only #1 after posedge, so negedge values are what the
  // next rising edge samples.
  always @(negedge clk) begin
    if (mem_en === 1'b1 && mem_grant === 1'b1) begin
      logic [47:0] e;
      writes++;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      check("mem_we", 64'(mem_we), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[47:32]));
        check("wr_data", 64'(mem_di), 64'(e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One bench cycle: drive, sample handshake at negedge, advance.
  task automatic step(input int f, input logic v, input logic g, output logic took);
    pix_valid = v;
    pix_in    = pv(f, pidx);
    mem_grant = g;
    @(negedge clk);
    took = pix_valid && pix_ready;
    tick();
    if (took) begin
      pidx++;
      if (pidx % 4 == 0) exp_q.push_back(exp_word(f, pidx/4 - 1));
    end
  endtask

  task automatic stream(input int f, input int vprob, input int gprob,
                        input int max_cyc, output int stalls);
    int cyc;
    logic took;
    cyc = 0;
    stalls = 0;
    while (pidx < NPIX && cyc < max_cyc) begin
      step(f, ($urandom_range(99) < vprob), ($urandom_range(99) < gprob), took);
      if (pix_valid && !took) stalls++;
      cyc++;
    end
    check("stream_complete", 64'(pidx), 64'(NPIX));
  endtask

  task automatic wait_done(input int gprob);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      mem_grant = ($urandom_range(99) < gprob);
      tick();
      cyc++;
    end
    check("done_high", 64'(done), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int stalls;
    int wbase;
    logic took;
    logic [47:0] w0;

    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0; mem_grant = 1'b0;
    #1;
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'(BASE));
    check("rst_mem_di", 64'(mem_di), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Free-run frame: 1 pixel/cycle, pixel i = i.
    pidx = 0; wbase = writes;
    pulse_start();
    check("ready_after_start", 64'(pix_ready), 64'd1);
    stream(0, 100, 100, NPIX + 10, stalls);
    check("freerun_no_stall", 64'(stalls), 64'd0);
    check("last_write_pending", 64'(mem_en), 64'd1);
    check("done_not_yet", 64'(done), 64'd0);
    tick();
    check("done_one_cycle_later", 64'(done), 64'd1);
    check("mem_en_after_done", 64'(mem_en), 64'd0);
    check("freerun_writes", 64'(writes - wbase), 64'(NWORD));

    // Extra input after the last pixel.
    wbase = writes;
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, 1'b1, took);
      check("extra_not_accepted", 64'(took), 64'd0);
    end
    check("extra_no_writes", 64'(writes - wbase), 64'd0);
    check("done_held", 64'(done), 64'd1);

    // Stall frame: grant low for 20 cycles, start pulse mid-frame ignored.
    pidx = 0; wbase = writes;
    pulse_start();
    check("restart_clears_done", 64'(done), 64'd0);
    w0 = exp_word(1, 0);
    for (int c = 0; c < 20; c++) begin
      start = (c == 10);
      step(1, 1'b1, 1'b0, took);
      if (c >= 3) begin
        check("stall_mem_en", 64'(mem_en), 64'd1);
        check("stall_addr", 64'(mem_addr), 64'(w0[47:32]));
        check("stall_data", 64'(mem_di), 64'(w0[31:0]));
      end
    end
    start = 1'b0;
    check("stall_accepted_8", 64'(pidx), 64'd8);
    check("stall_ready_low", 64'(pix_ready), 64'd0);
    stream(1, 100, 100, NPIX + 20, stalls);
    wait_done(100);
    check("stall_writes", 64'(writes - wbase), 64'(NWORD));

    // Random gaps and grants.
    pidx = 0; wbase = writes;
    pulse_start();
    check("gaps_done_cleared", 64'(done), 64'd0);
    stream(2, 50, 50, NPIX * 20, stalls);
    wait_done(50);
    check("gaps_writes", 64'(writes - wbase), 64'(NWORD));

    // Reset with a hold write pending.
    pidx = 0;
    pulse_start();
    for (int c = 0; c < 6; c++) step(3, 1'b1, 1'b0, took);
    check("pending_before_reset", 64'(mem_en), 64'd1);
    rst = 1'b0;
    #1;
    check("reset_mem_en", 64'(mem_en), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_pix_ready", 64'(pix_ready), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'(BASE));
    exp_q.delete();
    tick(); tick();
    rst = 1'b1;
    wbase = writes;
    for (int c = 0; c < 10; c++) step(3, 1'b1, 1'b1, took);
    check("post_reset_no_writes", 64'(writes - wbase), 64'd0);
    check("post_reset_no_accept", 64'(pidx), 64'd6);

    // Full frame after reset: first write back at BASE.
    pidx = 0; wbase = writes;
    pulse_start();
    stream(4, 100, 100, NPIX + 10, stalls);
    wait_done(100);
    check("after_reset_writes", 64'(writes - wbase), 64'(NWORD));

    pix_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
